cb_ingress_arb: RTL and testbench
=================================

Name: cb_ingress_arb

Overview:
- Round-robin, burst-locking arbiter that shares the crossbar buffer's single write port between IN ingress requesters.
- Tracks buffer occupancy with a credit counter so no write is issued when the buffer is full.
- Sits between the ingress requester ports and the buffer write side; the read side returns one credit per entry it pops.

Parameters:
- IN, 2, number of ingress requesters (>=2).
- DWIDTH, 32, data width per beat.
- BWIDTH, 3, buffer address width; DEPTH = 2**BWIDTH = 8 entries.
- MAXBURST, 4, maximum beats a requester may keep the grant before rotation (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- ireq  input  [IN]  per-requester valid; held until the beat is accepted.
- idata  input  [IN][DWIDTH]  per-requester beat data; stable while ireq is high.
- oresp  output  [IN]  per-requester ready; combinational. A beat transfers on a posedge where ireq[i] && oresp[i].
- wr_en  output  1  registered buffer write strobe.
- wr_data  output  DWIDTH  registered buffer write data.
- rd_pop  input  1  buffer read side consumed one entry (returns one credit).
- count  output  BWIDTH+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- grant_id  output  $clog2(IN)  current owner; valid only in OWN.
- pop_err  output  1  sticky; set when rd_pop arrives with count == 0.

Behaviour:
- Reset (async, any time, including mid-burst) clears all state:
  - FSM=IDLE, rr_last=IN-1, beat_cnt=0, count=0.
  - wr_en=0, wr_data=0, pop_err=0, grant_id=0.
  - oresp is all-zero while rst is high.
- FSM states: IDLE, OWN.
- IDLE:
  - oresp is all-zero.
  - If any ireq is high, pick the first requester with ireq high, searching round-robin from rr_last+1 upward with wrap.
  - Next state OWN; grant_id=pick; beat_cnt=0.
  - This costs a one-cycle arbitration bubble.
- OWN:
  - oresp[grant_id] = ireq[grant_id] && can_write; all other oresp bits are 0.
  - can_write = (count < DEPTH) || rd_pop. A write and a pop in the same cycle are allowed when full.
  - On a transfer, beat_cnt increments.
- OWN -> IDLE, with rr_last=grant_id, on either:
  - the MAXBURST-th transfer (beat_cnt == MAXBURST-1 at the transfer edge), or
  - ireq[grant_id] low at a posedge without a transfer.
- A stall caused by full does not end the burst; beat_cnt holds.
- Write path:
  - On a transfer edge, wr_en<=1 and wr_data<=idata[grant_id]; otherwise wr_en<=0.
  - wr_data holds its last value when wr_en=0.
  - Latency is one cycle from the acceptance edge to wr_en visible.
- Counter:
  - +1 on a transfer; -1 on rd_pop with count > 0.
  - Transfer and pop together: count unchanged.
  - rd_pop with count == 0: count stays 0 and pop_err is set (cleared only by rst).
  - count never exceeds DEPTH.
- Simultaneous requests are resolved strictly by round-robin order; no requester wins twice in a row while another is waiting, except when it is the only one requesting.
- No back-to-back grants: each ownership change passes through IDLE.

Decomposition:
- Shared package cb_pkg holds:
  - the arb_state_t enum {IDLE, OWN};
  - the buffer depth constant derived from BWIDTH, with count width BWIDTH+1.
- One sub-module, cb_rr_pick: combinational round-robin picker.
  - Inputs: req vector and last index.
  - Outputs: found flag and picked index.
  - Reused later by the egress side.

Test Plan:
- Single requester: ireq[0] high with 3 beats 0xA0,0xA1,0xA2 and no other traffic -> first oresp[0] in the cycle after ireq rises; wr_en pulses carry A0,A1,A2 one cycle after each acceptance; count=3.
- Fairness: ireq[0] and ireq[1] held high continuously, MAXBURST=4, rd_pop tied high -> grants alternate 0,1,0,1 in bursts of 4 beats, each separated by one IDLE cycle.
- Full: 8 beats with no rd_pop -> full=1, count=8, oresp low and ireq still high; one rd_pop in that cycle -> the beat is accepted and count stays 8.
- Underflow: rd_pop with count=0 -> count stays 0, pop_err=1 and remains set until rst.
- Owner drops early: requester 1 sends 2 beats then drops ireq while requester 0 is waiting -> IDLE for one cycle, then grant_id=0.
- Async reset mid-burst: assert rst between clock edges during a burst with count=5 -> every output is cleared immediately without a clock edge; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/cb_pkg.sv
// Shared types and constants for the crossbar buffer ingress/egress logic.
package cb_pkg;

  // Ingress arbiter states: waiting for requests, or a requester owns the write port.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Default buffer geometry: 2**BWIDTH entries, occupancy counter needs one extra bit.
  localparam int BWIDTH_DEFAULT = 3;
  localparam int DEPTH_DEFAULT  = 2 ** BWIDTH_DEFAULT;
  localparam int CNT_W_DEFAULT  = BWIDTH_DEFAULT + 1;

  // Buffer depth for a given address width.
  function automatic int depth_of(input int bw);
    return 2 ** bw;
  endfunction

endpackage

// File: rtl/cb_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping around.
module cb_rr_pick
  import cb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] candIdx;

  // Walk offsets 1..N from the last winner so the last winner is considered last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    candIdx = '0;
    for (int k = 1; k <= N; k++) begin
      candIdx = IW'((int'(last_i) + k) % N);
      if (!found_o && req_i[candIdx]) begin
        found_o = 1'b1;
        idx_o   = candIdx;
      end
    end
  end

endmodule

// File: rtl/cb_ingress_arb.sv
// Round-robin, burst-locking arbiter for the buffer write port with credit tracking.
module cb_ingress_arb
  import cb_pkg::*;
#(
  parameter  int IN       = 2,
  parameter  int DWIDTH   = 32,
  parameter  int BWIDTH   = BWIDTH_DEFAULT,
  parameter  int MAXBURST = 4,
  localparam int IW       = (IN > 1) ? $clog2(IN) : 1,
  localparam int CW       = BWIDTH + 1,
  localparam int BCW      = (MAXBURST > 1) ? $clog2(MAXBURST) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN-1:0]                ireq,
  input  logic [IN-1:0][DWIDTH-1:0]    idata,
  output logic [IN-1:0]                oresp,
  output logic                         wr_en,
  output logic [DWIDTH-1:0]            wr_data,
  input  logic                         rd_pop,
  output logic [CW-1:0]                count,
  output logic                         full,
  output logic [IW-1:0]                grant_id,
  output logic                         pop_err
);

  localparam logic [CW-1:0]  DEPTH_C   = CW'(depth_of(BWIDTH));
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAXBURST - 1);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       rr_last_q, rr_last_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [BCW-1:0]      beat_q, beat_d;
  logic [CW-1:0]       count_q;
  logic                wr_en_q;
  logic [DWIDTH-1:0]   wr_data_q;
  logic                pop_err_q;

  logic                pickFound;
  logic [IW-1:0]       pickIdx;
  logic                canWrite;
  logic                xfer;
  logic                popOk;

  cb_rr_pick #(.N(IN)) u_pick (
    .req_i   (ireq),
    .last_i  (rr_last_q),
    .found_o (pickFound),
    .idx_o   (pickIdx)
  );

  // A pop in the same cycle frees the slot a full buffer would otherwise block.
  assign canWrite = (count_q < DEPTH_C) || rd_pop;
  assign popOk    = rd_pop && (count_q != '0);

  // Next-state, ready and burst bookkeeping; every ownership change goes through IDLE.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    grant_d   = grant_q;
    beat_d    = beat_q;
    oresp     = '0;
    xfer      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pickFound) begin
          state_d = OWN;
          grant_d = pickIdx;
          beat_d  = '0;
        end
      end
      OWN: begin
        xfer           = ireq[grant_q] && canWrite;
        oresp[grant_q] = xfer;
        if (xfer) begin
          if (beat_q == LAST_BEAT) begin
            state_d   = IDLE;
            rr_last_d = grant_q;
            beat_d    = '0;
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end else if (!ireq[grant_q]) begin
          state_d   = IDLE;
          rr_last_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state register; rr_last starts at IN-1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= IW'(IN - 1);
      grant_q   <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      grant_q   <= grant_d;
      beat_q    <= beat_d;
    end
  end

  // Registered write strobe and data; data holds between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= xfer;
      if (xfer) begin
        wr_data_q <= idata[grant_q];
      end
    end
  end

  // Occupancy credits; a pop on an empty buffer is flagged and sticks until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      pop_err_q <= 1'b0;
    end else begin
      if (xfer && !popOk) begin
        count_q <= count_q + CW'(1);
      end else if (popOk && !xfer) begin
        count_q <= count_q - CW'(1);
      end
      if (rd_pop && (count_q == '0)) begin
        pop_err_q <= 1'b1;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign count    = count_q;
  assign full     = (count_q == DEPTH_C);
  assign grant_id = grant_q;
  assign pop_err  = pop_err_q;

endmodule

// File: tb/tb_cb_ingress_arb.sv
// Directed, table-driven bench for cb_ingress_arb (IN=2, 8-entry buffer, bursts of 4).
module tb_cb_ingress_arb;

  logic             clk;
  logic             rst;
  logic [1:0]       ireq;
  logic [1:0][31:0] idata;
  logic [1:0]       oresp;
  logic             wr_en;
  logic [31:0]      wr_data;
  logic             rd_pop;
  logic [3:0]       count;
  logic             full;
  logic [0:0]       grant_id;
  logic             pop_err;

  int nApplied;
  int nMiscompares;

  typedef struct {
    logic [1:0]  ireq;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        pop;
    logic [1:0]  oresp;
    logic        wrEn;
    logic [31:0] wrData;
    logic [3:0]  count;
    logic        grant;
    logic        popErr;
  } vec_t;

  vec_t vecs[17];

  cb_ingress_arb #(
    .IN(2), .DWIDTH(32), .BWIDTH(3), .MAXBURST(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ireq     (ireq),
    .idata    (idata),
    .oresp    (oresp),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_pop   (rd_pop),
    .count    (count),
    .full     (full),
    .grant_id (grant_id),
    .pop_err  (pop_err)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic [1:0] ir, input logic [31:0] a, input logic [31:0] b,
                              input logic p, input logic [1:0] orsp, input logic we,
                              input logic [31:0] wd, input logic [3:0] c, input logic g,
                              input logic pe);
    vec_t v;
    v.ireq = ir; v.d0 = a; v.d1 = b; v.pop = p; v.oresp = orsp; v.wrEn = we;
    v.wrData = wd; v.count = c; v.grant = g; v.popErr = pe;
    return v;
  endfunction

  task automatic applyStimulus(input logic [1:0] ir, input logic [31:0] a, input logic [31:0] b,
                               input logic p);
    ireq     = ir;
    idata[0] = a;
    idata[1] = b;
    rd_pop   = p;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] eOresp, input logic eWrEn,
                             input logic [31:0] eWrData, input logic [3:0] eCount,
                             input logic eFull, input logic eGrant, input logic ePopErr);
    nApplied++;
    if ({oresp, wr_en, wr_data, count, full, grant_id, pop_err} !==
        {eOresp, eWrEn, eWrData, eCount, eFull, eGrant, ePopErr}) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got oresp=%b wr_en=%b wr_data=%h count=%0d full=%b grant=%0d pop_err=%b, expected oresp=%b wr_en=%b wr_data=%h count=%0d full=%b grant=%0d pop_err=%b",
               name, oresp, wr_en, wr_data, count, full, grant_id, pop_err,
               eOresp, eWrEn, eWrData, eCount, eFull, eGrant, ePopErr);
    end
  endtask

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Main sequence: reset state, vector table, then the multi-cycle corner cases.
  initial begin
    nApplied     = 0;
    nMiscompares = 0;
    rst = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0);

    vecs[0]  = mk(2'b00, 32'h00, 32'h00, 1'b0, 2'b00, 1'b0, 32'h00, 4'd0, 1'b0, 1'b0);
    vecs[1]  = mk(2'b00, 32'h00, 32'h00, 1'b1, 2'b00, 1'b0, 32'h00, 4'd0, 1'b0, 1'b0);
    vecs[2]  = mk(2'b01, 32'hA0, 32'h00, 1'b0, 2'b00, 1'b0, 32'h00, 4'd0, 1'b0, 1'b1);
    vecs[3]  = mk(2'b01, 32'hA0, 32'h00, 1'b0, 2'b01, 1'b0, 32'h00, 4'd0, 1'b0, 1'b1);
    vecs[4]  = mk(2'b01, 32'hA1, 32'h00, 1'b0, 2'b01, 1'b1, 32'hA0, 4'd1, 1'b0, 1'b1);
    vecs[5]  = mk(2'b01, 32'hA2, 32'h00, 1'b0, 2'b01, 1'b1, 32'hA1, 4'd2, 1'b0, 1'b1);
    vecs[6]  = mk(2'b00, 32'hA2, 32'h00, 1'b0, 2'b00, 1'b1, 32'hA2, 4'd3, 1'b0, 1'b1);
    vecs[7]  = mk(2'b00, 32'h00, 32'h00, 1'b0, 2'b00, 1'b0, 32'hA2, 4'd3, 1'b0, 1'b1);
    vecs[8]  = mk(2'b11, 32'hB0, 32'hC0, 1'b0, 2'b00, 1'b0, 32'hA2, 4'd3, 1'b0, 1'b1);
    vecs[9]  = mk(2'b11, 32'hB0, 32'hC0, 1'b0, 2'b10, 1'b0, 32'hA2, 4'd3, 1'b1, 1'b1);
    vecs[10] = mk(2'b11, 32'hB0, 32'hC1, 1'b0, 2'b10, 1'b1, 32'hC0, 4'd4, 1'b1, 1'b1);
    vecs[11] = mk(2'b01, 32'hB0, 32'hC1, 1'b0, 2'b00, 1'b1, 32'hC1, 4'd5, 1'b1, 1'b1);
    vecs[12] = mk(2'b01, 32'hB0, 32'h00, 1'b0, 2'b00, 1'b0, 32'hC1, 4'd5, 1'b1, 1'b1);
    vecs[13] = mk(2'b01, 32'hB0, 32'h00, 1'b0, 2'b01, 1'b0, 32'hC1, 4'd5, 1'b0, 1'b1);
    vecs[14] = mk(2'b01, 32'hB1, 32'h00, 1'b1, 2'b01, 1'b1, 32'hB0, 4'd6, 1'b0, 1'b1);
    vecs[15] = mk(2'b00, 32'h00, 32'h00, 1'b1, 2'b00, 1'b1, 32'hB1, 4'd6, 1'b0, 1'b1);
    vecs[16] = mk(2'b00, 32'h00, 32'h00, 1'b0, 2'b00, 1'b0, 32'hB1, 4'd5, 1'b0, 1'b1);

    #2;
    checkOutput("reset_state", 2'b00, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step();
      applyStimulus(vecs[i].ireq, vecs[i].d0, vecs[i].d1, vecs[i].pop);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].oresp, vecs[i].wrEn, vecs[i].wrData,
                  vecs[i].count, (vecs[i].count == 4'd8), vecs[i].grant, vecs[i].popErr);
    end

    // Full buffer: two 4-beat bursts from requester 0 fill 8 entries.
    doReset();
    applyStimulus(2'b01, 32'h55, 32'h0, 1'b0);
    for (int i = 0; i < 11; i++) step();
    #1;
    checkOutput("full_stall", 2'b00, 1'b0, 32'h55, 4'd8, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b01, 32'h77, 32'h0, 1'b1);
    #1;
    checkOutput("full_pop_ready", 2'b01, 1'b0, 32'h55, 4'd8, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b0);
    #1;
    checkOutput("full_pop_accept", 2'b00, 1'b1, 32'h77, 4'd8, 1'b1, 1'b0, 1'b0);

    // Fairness: both requesting with pops always on -> alternating 4-beat bursts.
    doReset();
    applyStimulus(2'b11, 32'h100, 32'h200, 1'b1);
    for (int c = 0; c < 20; c++) begin
      logic [1:0] eResp;
      logic       eGrant;
      step();
      eGrant = 1'((c / 5) % 2);
      eResp  = ((c % 5) == 4) ? 2'b00 : (eGrant ? 2'b10 : 2'b01);
      checkValue($sformatf("fair_c%0d", c), {5'd0, eResp, eGrant}, {5'd0, oresp, grant_id});
    end

    // Async reset mid-burst with five entries buffered.
    doReset();
    applyStimulus(2'b01, 32'h99, 32'h0, 1'b0);
    for (int i = 0; i < 7; i++) step();
    #1;
    checkOutput("pre_async_rst", 2'b01, 1'b1, 32'h99, 4'd5, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 2'b00, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    ireq = 2'b11;
    #3;
    rst = 1'b0;
    step();
    checkValue("post_rst_grant", {5'd0, oresp, grant_id}, {5'd0, 2'b01, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule
